// File: rtl/mmio_timer_if.sv
// LSU data-bus signals between the core's load/store unit and the timer.
// The slave modport is the timer's view; the master modport is the requester's view.
interface mmio_timer_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        hit_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output rdata_o, hit_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  rdata_o, hit_o
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match and a level interrupt.
// Registers: CTRL (0x0), COUNT (0x4), CMP (0x8), STATUS (0xC, W1C match flag).
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    mmio_timer_if.slave bus,
    output logic        irq_o
);

    logic               en_q, en_d;
    logic               ar_q, ar_d;
    logic               ie_q, ie_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        cmp_q, cmp_d;
    logic               match_q, match_d;
    logic               irq_d;

    logic        hit;
    logic [1:0]  idx;
    logic        wr, wr_ctrl, wr_cnt, wr_cmp, wr_sts;
    logic        presc_wr;
    logic        tick, match_evt;
    logic [31:0] bmask;
    logic [31:0] ctrl_rd;
    logic [31:0] ctrl_new;
    logic        unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign hit         = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
    assign idx         = bus.addr_i[3:2];
    assign unused_bits = ^{bus.addr_i[1:0], ctrl_new[31:8+PRESC_W], ctrl_new[7:3]};
    assign bmask       = {{8{bus.be_i[3]}}, {8{bus.be_i[2]}}, {8{bus.be_i[1]}}, {8{bus.be_i[0]}}};
    assign ctrl_rd     = {{(24-PRESC_W){1'b0}}, presc_q, 5'b0, ie_q, ar_q, en_q};
    assign ctrl_new    = merge_bytes(ctrl_rd, bus.wdata_i, bmask);

    assign wr      = bus.req_i && bus.we_i && hit;
    assign wr_ctrl = wr && (idx == 2'd0);
    assign wr_cnt  = wr && (idx == 2'd1);
    assign wr_cmp  = wr && (idx == 2'd2);
    assign wr_sts  = wr && (idx == 2'd3);

    assign presc_wr  = wr_ctrl && (|bmask[8 +: PRESC_W]);
    assign tick      = en_q && (pcnt_q == presc_q);
    // Compare always uses the registered COUNT/CMP, so same-cycle writes never affect this tick's match.
    assign match_evt = tick && (cnt_q == cmp_q);

    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        if (wr_ctrl) begin
            en_d    = ctrl_new[0];
            ar_d    = ctrl_new[1];
            ie_d    = ctrl_new[2];
            presc_d = ctrl_new[8 +: PRESC_W];
        end

        if (!en_d || presc_wr || tick) pcnt_d = '0;
        else                           pcnt_d = pcnt_q + PRESC_W'(1);

        cnt_d = cnt_q;
        if (tick) cnt_d = (match_evt && ar_q) ? 32'd0 : cnt_q + 32'd1;
        if (wr_cnt) cnt_d = merge_bytes(cnt_q, bus.wdata_i, bmask);

        cmp_d = wr_cmp ? merge_bytes(cmp_q, bus.wdata_i, bmask) : cmp_q;

        // A new match outranks a same-cycle W1C clear.
        match_d = match_q;
        if (wr_sts && bus.be_i[0] && bus.wdata_i[0]) match_d = 1'b0;
        if (match_evt) match_d = 1'b1;

        irq_d = match_d && ie_d;
    end

    always_comb begin
        bus.rdata_o = 32'h0;
        if (hit && bus.req_i && !bus.we_i) begin
            case (idx)
                2'd0:    bus.rdata_o = ctrl_rd;
                2'd1:    bus.rdata_o = cnt_q;
                2'd2:    bus.rdata_o = cmp_q;
                default: bus.rdata_o = {31'b0, match_q};
            endcase
        end
    end

    assign bus.hit_o = hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            cnt_q   <= 32'h0;
            cmp_q   <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            irq_o   <= irq_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reads push expected values into a queue, a negedge monitor
// pops and compares whenever a read is presented on the bus.
module tb_mmio_timer;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_CNT  = BASE + 32'h4;
    localparam logic [31:0] A_CMP  = BASE + 32'h8;
    localparam logic [31:0] A_STS  = BASE + 32'hC;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        hit;
        int          irq;
    } exp_t;

    logic clk;
    logic reset;
    logic irq;
    mmio_timer_if bus();

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.be_i    = 4'h0;
        bus.addr_i  = 32'h0;
        bus.wdata_i = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.be_i    = be;
        bus.addr_i  = addr;
        bus.wdata_i = data;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_hit,
                      input int exp_irq, input string name);
        exp_t e;
        e.name  = name;
        e.rdata = exp_data;
        e.hit   = exp_hit;
        e.irq   = exp_irq;
        exp_q.push_back(e);
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.be_i   = 4'h0;
        bus.addr_i = addr;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    always @(negedge clk) begin
        if (bus.req_i && !bus.we_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: rdata=%h with no expected entry", bus.rdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.rdata_o !== e.rdata || bus.hit_o !== e.hit ||
                    (e.irq >= 0 && irq !== e.irq[0])) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h hit=%b irq=%b, required rdata=%h hit=%b irq=%0d",
                             e.name, bus.rdata_o, bus.hit_o, irq, e.rdata, e.hit, e.irq);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-count with irq asserted
        wr(A_CMP, 32'd2, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        idle(6);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rd(A_CTRL, 32'h0, 1'b1, 0, "rst_ctrl");
        rd(A_CNT, 32'h0, 1'b1, 0, "rst_count");
        rd(A_CMP, 32'hFFFF_FFFF, 1'b1, 0, "rst_cmp");
        rd(A_STS, 32'h0, 1'b1, 0, "rst_status");

        // Basic compare with auto-reload and interrupt
        wr(A_CMP, 32'd5, 4'hF);
        wr(A_CTRL, 32'h7, 4'hF);
        for (int i = 0; i < 6; i++) rd(A_CNT, 32'(i), 1'b1, 0, "basic_count");
        rd(A_STS, 32'h1, 1'b1, 1, "basic_match_irq");
        rd(A_CNT, 32'h1, 1'b1, 1, "basic_reload");
        wr(A_STS, 32'h1, 4'h1);
        rd(A_STS, 32'h0, 1'b1, 0, "basic_w1c_irq_low");
        wr(A_CTRL, 32'h0, 4'hF);

        // Prescale of 3: one increment every 4 cycles
        wr(A_CMP, 32'hFFFF_FFFF, 4'hF);
        wr(A_CNT, 32'h0, 4'hF);
        wr(A_CTRL, 32'h301, 4'hF);
        idle(39);
        rd(A_CNT, 32'd9, 1'b1, -1, "presc_39cyc");
        rd(A_CNT, 32'd10, 1'b1, -1, "presc_40cyc");
        wr(A_CTRL, 32'h0, 4'hF);

        // Byte enables, CTRL reserved bits and address miss
        wr(A_CNT, 32'h0, 4'hF);
        wr(A_CNT, 32'hAABB_CCDD, 4'b0101);
        rd(A_CNT, 32'h00BB_00DD, 1'b1, -1, "be_count");
        wr(BASE + 32'h10, 32'h1234_5678, 4'hF);
        rd(A_CNT, 32'h00BB_00DD, 1'b1, -1, "miss_no_write");
        rd(BASE + 32'h14, 32'h0, 1'b0, -1, "miss_read");
        wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
        rd(A_CTRL, 32'h0000_FF00, 1'b1, -1, "ctrl_reserved");
        wr(A_CTRL, 32'h0, 4'hF);

        // Collisions: W1C against new match, COUNT write against tick
        wr(A_CNT, 32'h0, 4'hF);
        wr(A_CMP, 32'd2, 4'hF);
        wr(A_CTRL, 32'h3, 4'hF);
        idle(2);
        wr(A_STS, 32'h1, 4'h1);
        rd(A_STS, 32'h1, 1'b1, 0, "coll_w1c_vs_match");
        wr(A_CNT, 32'h100, 4'hF);
        rd(A_CNT, 32'h100, 1'b1, -1, "coll_write_vs_tick");
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_STS, 32'h1, 4'h1);
        rd(A_STS, 32'h0, 1'b1, 0, "coll_clear");

        // Wrap through zero without reload
        wr(A_CMP, 32'd3, 4'hF);
        wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        rd(A_CNT, 32'hFFFF_FFFE, 1'b1, -1, "wrap_fffe");
        rd(A_CNT, 32'hFFFF_FFFF, 1'b1, -1, "wrap_ffff");
        rd(A_CNT, 32'h0, 1'b1, -1, "wrap_zero");
        rd(A_CNT, 32'h1, 1'b1, -1, "wrap_one");
        rd(A_CNT, 32'h2, 1'b1, -1, "wrap_two");
        rd(A_STS, 32'h0, 1'b1, 0, "wrap_no_flag");
        rd(A_CNT, 32'h4, 1'b1, -1, "wrap_no_reload");
        rd(A_STS, 32'h1, 1'b1, 0, "wrap_match");
        wr(A_CTRL, 32'h0, 4'hF);

        idle(2);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
